wakeup_queue: RTL and testbench
===============================

WAKEUP_QUEUE -- requirements
Module: wakeup_queue

Interface
REQ-001 SHALL have parameter NUM_FUS, default CORE_PKG::NUM_FUS, the functional-unit count; each dependency vector is 2*NUM_FUS bits (LW).
REQ-002 SHALL have parameter DEPTH, default 4, the number of queue entries (power of two, 2..16).
REQ-003 SHALL have parameter TAG_W, default 6, the payload tag width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-006 SHALL have port dispatch_valid, input, 1, dispatch presents an instruction.
REQ-007 SHALL have port src1_dp_en, input, 1, src1 waits on an in-flight producer.
REQ-008 SHALL have port src2_dp_en, input, 1, src2 waits on an in-flight producer.
REQ-009 SHALL have port src1_dp_loc, input, LW, producer slot bits src1 waits on.
REQ-010 SHALL have port src2_dp_loc, input, LW, producer slot bits src2 waits on.
REQ-011 SHALL have port dispatch_tag, input, TAG_W, payload stored with the entry.
REQ-012 SHALL have port entry_free, output, 1, at least one entry is invalid.
REQ-013 SHALL have port wakeup_vec, input, LW, producer slots completing this cycle.
REQ-014 SHALL have port issue_valid, output, 1, a ready entry is presented.
REQ-015 SHALL have port issue_ready, input, 1, the consumer accepts the presented entry.
REQ-016 SHALL have port issue_tag, output, TAG_W, tag of the presented entry.
REQ-017 SHALL have port occupancy, output, $clog2(DEPTH)+1, count of valid entries.

Function
REQ-018 SHALL store per entry: valid, src1 mask (LW), src2 mask (LW), tag.
REQ-019 SHALL drive entry_free combinationally as OR of ~valid over current state; it does not count entries freed by an issue in the same cycle.
REQ-020 SHALL accept a dispatch when dispatch_valid && entry_free, writing the lowest-index invalid entry; dispatch_valid with entry_free=0 is ignored and changes no state.
REQ-021 SHALL write a src mask as zero when its dp_en=0, else as dp_loc & ~wakeup_vec, so a wakeup in the dispatch cycle is not lost.
REQ-022 SHALL, every cycle, clear wakeup_vec bits from both masks of every valid entry.
REQ-023 SHALL deem an entry ready when valid and both stored masks are zero.
REQ-024 SHALL present the lowest-index ready entry on issue_tag with issue_valid=1; with none ready, issue_valid=0 and issue_tag=0.
REQ-025 SHALL invalidate the presented entry on the edge where issue_valid && issue_ready; a held entry keeps issue_tag stable unless a lower-index entry becomes ready.
REQ-026 SHALL, on simultaneous dispatch and issue, perform both; occupancy changes by net 0.
REQ-027 SHALL keep occupancy equal to the popcount of valid bits (+1 dispatch, -1 issue, saturation impossible by REQ-020).
REQ-028 SHALL ignore wakeup_vec bits that match no pending mask.

Reset
REQ-029 SHALL, on rst_n low, immediately clear all valid bits, masks and tags; entry_free=1, issue_valid=0, issue_tag=0, occupancy=0.
REQ-030 SHALL discard in-flight entries on reset mid-operation; none issues after release.
REQ-031 SHALL accept dispatch on the first rising edge with rst_n high.

Configuration
REQ-032 SHALL, with WAKEUP_BYPASS_EN defined, treat an entry as ready when (mask & ~wakeup_vec)==0 for both sources, so it can issue in the same cycle its last wakeup arrives.
REQ-033 SHALL, without WAKEUP_BYPASS_EN, evaluate readiness on registered masks only; earliest issue is the cycle after the last wakeup.

Verification (NUM_FUS=2, LW=4, DEPTH=4)
REQ-034 SHALL cover: dispatch tag=5 with both dp_en=0, issue_ready=1 -> issue_valid=1, issue_tag=5 next cycle, occupancy 1 -> 0.
REQ-035 SHALL cover: dispatch tag=7 with src1_dp_loc=4'b0100, wakeup_vec=4'b0100 two cycles later -> issue in that cycle with bypass, one cycle later without.
REQ-036 SHALL cover: four dispatches, issue_ready=0 -> entry_free=0, occupancy=4; a fifth dispatch_valid is dropped; after one issue, entry_free=1.
REQ-037 SHALL cover: dispatch src2_dp_loc=4'b0010 with wakeup_vec=4'b0010 in the same cycle -> entry ready next cycle (mask written zero).
REQ-038 SHALL cover: entries 0 and 2 ready, issue_ready=0 for 3 cycles -> issue_tag holds entry 0's tag; after accept, entry 2 is presented.
REQ-039 SHALL cover: rst_n pulsed low with 3 valid entries -> outputs reset asynchronously, nothing issues afterwards.

Source files
------------

// File: rtl/wakeup_queue.sv
// Out-of-order wakeup/issue queue: entries wait on producer slot bits and issue lowest-index-first once clear.
// Optional macro WAKEUP_BYPASS_EN lets an entry issue in the same cycle its last wakeup arrives.
module wakeup_queue #(
  parameter int NUM_FUS = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 6,
  localparam int LW     = 2 * NUM_FUS,
  localparam int IW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dispatch_valid,
  input  logic             src1_dp_en,
  input  logic             src2_dp_en,
  input  logic [LW-1:0]    src1_dp_loc,
  input  logic [LW-1:0]    src2_dp_loc,
  input  logic [TAG_W-1:0] dispatch_tag,
  output logic             entry_free,
  input  logic [LW-1:0]    wakeup_vec,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [TAG_W-1:0] issue_tag,
  output logic [CW-1:0]    occupancy
);

  logic [DEPTH-1:0] ent_vld;
  logic [LW-1:0]    src1_mask [DEPTH];
  logic [LW-1:0]    src2_mask [DEPTH];
  logic [TAG_W-1:0] ent_tag   [DEPTH];

  logic [DEPTH-1:0] ready_vec;
  logic [IW-1:0]    issue_idx;
  logic [IW-1:0]    free_idx;
  logic             do_dispatch;
  logic             do_issue;
  logic [LW-1:0]    src1_wr;
  logic [LW-1:0]    src2_wr;

  function automatic logic [IW-1:0] first_set(input logic [DEPTH-1:0] v);
    first_set = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) first_set = IW'(i);
    end
  endfunction

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef WAKEUP_BYPASS_EN
      ready_vec[i] = ent_vld[i] &&
                     ((src1_mask[i] & ~wakeup_vec) == '0) &&
                     ((src2_mask[i] & ~wakeup_vec) == '0);
`else
      ready_vec[i] = ent_vld[i] && (src1_mask[i] == '0) && (src2_mask[i] == '0);
`endif
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + CW'(ent_vld[i]);
    end
  end

  assign entry_free  = |(~ent_vld);
  assign free_idx    = first_set(~ent_vld);
  assign issue_idx   = first_set(ready_vec);
  assign issue_valid = |ready_vec;
  assign issue_tag   = issue_valid ? ent_tag[issue_idx] : '0;
  assign do_dispatch = dispatch_valid & entry_free;
  assign do_issue    = issue_valid & issue_ready;

  // A wakeup landing in the dispatch cycle is folded into the written mask.
  assign src1_wr = src1_dp_en ? (src1_dp_loc & ~wakeup_vec) : '0;
  assign src2_wr = src2_dp_en ? (src2_dp_loc & ~wakeup_vec) : '0;

  // Entry state: the dispatch slot is always invalid, so it never collides with the issue slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        src1_mask[i] <= '0;
        src2_mask[i] <= '0;
        ent_tag[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        src1_mask[i] <= src1_mask[i] & ~wakeup_vec;
        src2_mask[i] <= src2_mask[i] & ~wakeup_vec;
        if (do_issue && (issue_idx == IW'(i))) begin
          ent_vld[i] <= 1'b0;
        end
        if (do_dispatch && (free_idx == IW'(i))) begin
          ent_vld[i]   <= 1'b1;
          src1_mask[i] <= src1_wr;
          src2_mask[i] <= src2_wr;
          ent_tag[i]   <= dispatch_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_wakeup_queue.sv
// Directed bench for wakeup_queue (NUM_FUS=2, DEPTH=4) with a per-cycle reference model of the queue.
module tb_wakeup_queue;

`ifdef WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  bit          clk = 1'b0;
  logic        rst_n;
  logic        dispatch_valid;
  logic        src1_dp_en;
  logic        src2_dp_en;
  logic [3:0]  src1_dp_loc;
  logic [3:0]  src2_dp_loc;
  logic [5:0]  dispatch_tag;
  logic        entry_free;
  logic [3:0]  wakeup_vec;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_tag;
  logic [2:0]  occupancy;

  wakeup_queue #(.NUM_FUS(2), .DEPTH(4), .TAG_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dispatch_valid (dispatch_valid),
    .src1_dp_en     (src1_dp_en),
    .src2_dp_en     (src2_dp_en),
    .src1_dp_loc    (src1_dp_loc),
    .src2_dp_loc    (src2_dp_loc),
    .dispatch_tag   (dispatch_tag),
    .entry_free     (entry_free),
    .wakeup_vec     (wakeup_vec),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_tag      (issue_tag),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one record per slot.
  typedef struct packed {
    bit       v;
    bit [3:0] m1;
    bit [3:0] m2;
    bit [5:0] tag;
  } ent_t;

  ent_t mq    [4];
  ent_t mq_nx [4];

  function automatic bit ent_ready(input ent_t e, input logic [3:0] wv);
    if (!e.v) return 1'b0;
    if (BYP) return ((e.m1 & ~wv) == 4'd0) && ((e.m2 & ~wv) == 4'd0);
    return (e.m1 == 4'd0) && (e.m2 == 4'd0);
  endfunction

  always @(negedge clk) begin : cmp
    int  ei, etag, eocc, k;
    bit  eiv, efree;
    if (!rst_n) begin
      chk("m_rst_valid", 32'(issue_valid), 0);
      chk("m_rst_tag",   32'(issue_tag),   0);
      chk("m_rst_free",  32'(entry_free),  1);
      chk("m_rst_occ",   32'(occupancy),   0);
      for (int i = 0; i < 4; i++) mq_nx[i] = '0;
    end else begin
      eiv = 1'b0; ei = 0; efree = 1'b0; eocc = 0; k = 0;
      for (int i = 3; i >= 0; i--) begin
        if (ent_ready(mq[i], wakeup_vec)) begin
          eiv = 1'b1;
          ei  = i;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (mq[i].v) eocc++;
        else efree = 1'b1;
      end
      etag = eiv ? int'(mq[ei].tag) : 0;
      chk("m_issue_valid", 32'(issue_valid), 32'(eiv));
      chk("m_issue_tag",   32'(issue_tag),   etag);
      chk("m_entry_free",  32'(entry_free),  32'(efree));
      chk("m_occupancy",   32'(occupancy),   eocc);
      for (int i = 0; i < 4; i++) begin
        mq_nx[i]    = mq[i];
        mq_nx[i].m1 = mq[i].m1 & ~wakeup_vec;
        mq_nx[i].m2 = mq[i].m2 & ~wakeup_vec;
      end
      if (eiv && issue_ready) mq_nx[ei].v = 1'b0;
      if (dispatch_valid && efree) begin
        for (int i = 3; i >= 0; i--) if (!mq[i].v) k = i;
        mq_nx[k].v   = 1'b1;
        mq_nx[k].m1  = src1_dp_en ? (src1_dp_loc & ~wakeup_vec) : 4'd0;
        mq_nx[k].m2  = src2_dp_en ? (src2_dp_loc & ~wakeup_vec) : 4'd0;
        mq_nx[k].tag = dispatch_tag;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mq[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) mq[i] <= mq_nx[i];
    end
  end

  task automatic idle();
    dispatch_valid = 1'b0;
    src1_dp_en     = 1'b0;
    src2_dp_en     = 1'b0;
    src1_dp_loc    = 4'd0;
    src2_dp_loc    = 4'd0;
    dispatch_tag   = 6'd0;
    wakeup_vec     = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    issue_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_free",  32'(entry_free),  1);
    chk("rst_valid", 32'(issue_valid), 0);
    chk("rst_occ",   32'(occupancy),   0);
    rst_n = 1'b1;

    // Dispatch on the first edge after release; ready entry issues next cycle.
    dispatch_valid = 1'b1; dispatch_tag = 6'd5; issue_ready = 1'b1;
    tick(); idle(); #1;
    chk("t1_valid", 32'(issue_valid), 1);
    chk("t1_tag",   32'(issue_tag),   5);
    chk("t1_occ",   32'(occupancy),   1);
    tick();
    chk("t1_occ_after",   32'(occupancy),   0);
    chk("t1_valid_after", 32'(issue_valid), 0);

    // Single dependency woken two cycles after dispatch.
    dispatch_valid = 1'b1; dispatch_tag = 6'd7; src1_dp_en = 1'b1; src1_dp_loc = 4'b0100;
    tick(); idle(); #1;
    chk("t2_waiting", 32'(issue_valid), 0);
    tick(); wakeup_vec = 4'b0100; #1;
    chk("t2_wake_valid", 32'(issue_valid), 32'(BYP));
    chk("t2_wake_tag",   32'(issue_tag),   BYP ? 7 : 0);
    tick(); wakeup_vec = 4'd0; #1;
    chk("t2_late_valid", 32'(issue_valid), 32'(!BYP));
    chk("t2_late_tag",   32'(issue_tag),   BYP ? 0 : 7);
    tick();
    chk("t2_occ_after", 32'(occupancy), 0);

    // Fill the queue, then a fifth dispatch is dropped.
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dispatch_valid = 1'b1; dispatch_tag = 6'(10 + i);
      tick();
    end
    chk("t3_full_free", 32'(entry_free), 0);
    chk("t3_full_occ",  32'(occupancy),  4);
    dispatch_tag = 6'd14;
    tick(); idle(); #1;
    chk("t3_drop_occ", 32'(occupancy), 4);
    chk("t3_head_tag", 32'(issue_tag), 10);
    issue_ready = 1'b1;
    tick();
    chk("t3_free_again", 32'(entry_free), 1);
    chk("t3_occ_three",  32'(occupancy),  3);
    chk("t3_next_tag",   32'(issue_tag),  11);
    repeat (3) tick();
    chk("t3_drained_occ",   32'(occupancy),   0);
    chk("t3_drained_valid", 32'(issue_valid), 0);

    // Wakeup in the dispatch cycle clears the written mask.
    issue_ready = 1'b0;
    dispatch_valid = 1'b1; dispatch_tag = 6'd20; src2_dp_en = 1'b1; src2_dp_loc = 4'b0010;
    wakeup_vec = 4'b0010;
    tick(); idle(); #1;
    chk("t4_valid", 32'(issue_valid), 1);
    chk("t4_tag",   32'(issue_tag),   20);
    issue_ready = 1'b1;
    tick();
    chk("t4_occ_after", 32'(occupancy), 0);

    // Entries 0 and 2 ready, entry 1 blocked; head holds while stalled.
    issue_ready = 1'b0;
    dispatch_valid = 1'b1; dispatch_tag = 6'd30;
    tick();
    src1_dp_en = 1'b1; src1_dp_loc = 4'b0001; dispatch_tag = 6'd31;
    tick();
    src1_dp_en = 1'b0; src1_dp_loc = 4'd0; dispatch_tag = 6'd32;
    tick(); idle(); #1;
    for (int c = 0; c < 3; c++) begin
      chk("t5_hold_tag",   32'(issue_tag),   30);
      chk("t5_hold_valid", 32'(issue_valid), 1);
      tick();
    end
    issue_ready = 1'b1;
    tick(); issue_ready = 1'b0; #1;
    chk("t5_second_tag", 32'(issue_tag), 32);
    wakeup_vec = 4'b0001; #1;
    chk("t5_wake_tag", 32'(issue_tag), BYP ? 31 : 32);
    tick(); wakeup_vec = 4'd0; #1;
    chk("t5_lower_tag", 32'(issue_tag), 31);
    dispatch_valid = 1'b1; dispatch_tag = 6'd33; src1_dp_en = 1'b1; src1_dp_loc = 4'b1000;
    tick(); idle(); #1;
    chk("t5_occ_three", 32'(occupancy), 3);
    chk("t5_keep_tag",  32'(issue_tag), 31);

    // Asynchronous reset with three live entries; nothing issues afterwards.
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_free",  32'(entry_free),  1);
    chk("t6_async_valid", 32'(issue_valid), 0);
    chk("t6_async_occ",   32'(occupancy),   0);
    chk("t6_async_tag",   32'(issue_tag),   0);
    tick();
    rst_n = 1'b1; issue_ready = 1'b1; wakeup_vec = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t6_no_issue", 32'(issue_valid), 0);
      tick();
    end
    wakeup_vec = 4'd0; #1;
    chk("t6_occ_final", 32'(occupancy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
